alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
ID/EX issue stage that feeds the alu block. It decodes RV32I OP and OP-IMM instructions into the 4-bit Alu_ctrl code and selects the operands. It registers the result into a single pipeline slot, with valid/ready handshakes on both sides and a flush input. This is the producer end of the alu interface: it drives a, b and Alu_ctrl, and the alu returns Result and Zero.

Parameters:
XLEN, 32, datapath width (only 32 is supported)

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  synchronous, active-low reset
flush  in  1  kills the held slot and the current input (branch/trap redirect)
in_valid  in  1  the decode side presents an instruction
in_ready  out  1  the slot can accept an instruction this cycle
instr  in  32  instruction word
rs1_data  in  XLEN  register-file read port 1
rs2_data  in  XLEN  register-file read port 2
pc  in  XLEN  instruction address (used only under the optional feature)
out_valid  out  1  the slot holds an issued op
out_ready  in  1  EX consumes the slot this cycle
alu_a  out  XLEN  drives alu.a
alu_b  out  XLEN  drives alu.b
alu_ctrl  out  4  drives alu.Alu_ctrl
rd  out  5  destination register
wb_en  out  1  write-back enable; 0 when rd==0 or the op is illegal
illegal  out  1  the issued instruction failed decode

Behaviour:
- Reset (rst_n=0 at an edge): out_valid=0, alu_a=0, alu_b=0, alu_ctrl=0000, rd=0, wb_en=0, illegal=0. Reset overrides flush and any handshake; an op held mid-handshake is dropped.
- in_ready = !out_valid || out_ready, a combinational function of the slot state.
- Load: when in_valid && in_ready && !flush, the decoded fields are captured at the edge and out_valid becomes 1 on the next cycle. Latency is 1 cycle from input handshake to out_valid.
- Consume: when out_valid && out_ready and there is no new load, out_valid goes to 0. A consume and a load in the same cycle give back-to-back throughput of 1 op per cycle.
- Hold: when out_valid && !out_ready, every output stays stable. Outputs must not change while out_valid=1 until the handshake completes.
- Flush: out_valid is 0 on the next cycle and the input is not captured, even when in_valid && in_ready. Data registers may keep stale values.
- Alu_ctrl encoding is fixed: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLTU 1000, SLT 1001.
- OP (opcode 0110011): alu_a = rs1_data, alu_b = rs2_data.
  - funct7 = 0000000 is legal for all funct3 values.
  - funct7 = 0100000 is legal only with funct3 000 (SUB) or 101 (SRA).
- OP-IMM (opcode 0010011): alu_a = rs1_data, alu_b = sign-extended instr[31:20].
  - SLLI requires instr[31:25] = 0000000.
  - SRLI/SRAI require instr[31:25] to be 0000000 or 0100000; alu_b = {27'b0, instr[24:20]}.
  - There is no SUBI; ADDI always maps to ADD.
- Illegal (any other opcode or a bad funct7): the op is still issued so EX sees it. Outputs are illegal=1, alu_ctrl=ADD, alu_a=0, alu_b=0, wb_en=0.
- rd = instr[11:7]. wb_en = !illegal && (rd != 0).
- The input is not captured when in_valid=0, whatever the other inputs are.

Optional Feature:
ALU_ISSUE_UPPER_EN
- Defined: two extra legal opcodes are decoded, both with alu_b = {instr[31:12], 12'b0} and alu_ctrl = ADD.
  - LUI (0110111): alu_a = 0.
  - AUIPC (0010111): alu_a = pc.
- Undefined: these opcodes are illegal, pc is ignored, and the logic is removed.

Decomposition:
- Shared package alu_pkg holds:
  - the ALU_* 4-bit Alu_ctrl constants;
  - the opcode constants OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC;
  - the funct7 constants F7_BASE and F7_ALT.
- The alu block must import the same package so both ends agree on the encoding.
- One natural sub-module, alu_dec: purely combinational, instr/rs1/rs2/pc in, a/b/ctrl/illegal out. alu_issue wraps it with the slot register and handshake logic.

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1=10, rs2=20, out_ready=1 -> next cycle out_valid=1, alu_a=10, alu_b=20, alu_ctrl=0000, rd=3, wb_en=1.
- sub (0x402081B3), rs1=100, rs2=100 -> alu_ctrl=0001. A connected alu returns Result=0, Zero=1.
- addi x1,x0,-10 (0xFF600093) -> alu_b=0xFFFFFFF6, ctrl=0000. Then slli x5,x1,2 (0x00209293) -> alu_b=2, ctrl=0101.
- slt (0x0020A1B3), rs1=0xFFFFFFF6, rs2=5, with out_ready=0 for 3 cycles -> in_ready=0 and outputs stable with ctrl=1001. The op is consumed on the first out_ready=1; the alu result is 1.
- 0x4020F1B3 (AND with funct7 0100000) -> illegal=1, wb_en=0, ctrl=0000, a=b=0. Opcode 0110111 -> illegal=1 without the macro; with ALU_ISSUE_UPPER_EN, alu_a=0 and alu_b=instr[31:12]<<12.
- flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0 and the input is not captured. rst_n=0 mid-hold -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared encoding package for the ALU interface. The issue stage (alu_issue,
// alu_dec) and the alu block both import this package, so the Alu_ctrl codes,
// opcodes and funct7 patterns are the same at both ends.
//
// Contents:
//   ALU_*      4-bit Alu_ctrl operation codes
//   OPC_*      RV32I major opcodes decoded by the issue stage
//   F7_*       funct7 patterns for base and alternate (SUB/SRA) encodings
//   F3_*       funct3 selectors shared by OP and OP-IMM
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b1001;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Base-encoding Alu_ctrl for a funct3 value; the alternate funct7 only
    // changes ADD->SUB and SRL->SRA, which callers handle themselves.
    function automatic logic [3:0] f3_to_ctrl(input logic [2:0] f3);
        logic [3:0] c;
        case (f3)
            F3_ADD:  c = ALU_ADD;
            F3_SLL:  c = ALU_SLL;
            F3_SLT:  c = ALU_SLT;
            F3_SLTU: c = ALU_SLTU;
            F3_XOR:  c = ALU_XOR;
            F3_SR:   c = ALU_SRL;
            F3_OR:   c = ALU_OR;
            default: c = ALU_AND;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_dec.sv
// -----------------------------------------------------------------------------
// alu_dec
// Purely combinational RV32I OP / OP-IMM decoder. Produces the ALU operands,
// the Alu_ctrl code and an illegal flag. Illegal ops are forced to ADD with
// zero operands so that EX sees a harmless operation.
//
// Optional feature macro: ALU_ISSUE_UPPER_EN
//   defined   -> LUI and AUIPC decode as legal ADDs with the U-immediate
//   undefined -> both opcodes are illegal and pc is ignored
//
// Ports:
//   instr     in   32    instruction word
//   rs1_data  in   XLEN  register-file read port 1
//   rs2_data  in   XLEN  register-file read port 2
//   pc        in   XLEN  instruction address (AUIPC only)
//   a         out  XLEN  ALU operand a
//   b         out  XLEN  ALU operand b
//   ctrl      out  4     Alu_ctrl code
//   illegal   out  1     decode failed
// -----------------------------------------------------------------------------
module alu_dec #(
    parameter int XLEN = 32
) (
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  a,
    output logic [XLEN-1:0]  b,
    output logic [3:0]       ctrl,
    output logic             illegal
);
    import alu_pkg::*;

    logic [6:0]             opcode;
    logic [2:0]             funct3;
    logic [6:0]             funct7;
    logic signed [XLEN-1:0] imm_i;
    logic [XLEN-1:0]        shamt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = XLEN'($signed(instr[31:20]));
    assign shamt  = XLEN'(instr[24:20]);

    // Register-index fields are consumed by the issue stage, not here.
    logic unused_fields;
    assign unused_fields = ^{instr[19:15], instr[11:7]};

`ifdef ALU_ISSUE_UPPER_EN
    logic [XLEN-1:0] imm_u;
    assign imm_u = XLEN'({instr[31:12], 12'b0});
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

    always_comb begin
        a       = '0;
        b       = '0;
        ctrl    = ALU_ADD;
        illegal = 1'b0;

        case (opcode)
            OPC_OP: begin
                a    = rs1_data;
                b    = rs2_data;
                ctrl = f3_to_ctrl(funct3);
                if (funct7 == F7_BASE) begin
                    illegal = 1'b0;
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    ctrl = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
                    ctrl = ALU_SRA;
                end else begin
                    illegal = 1'b1;
                end
            end

            OPC_OPIMM: begin
                a    = rs1_data;
                b    = imm_i;
                ctrl = f3_to_ctrl(funct3);
                // Shift immediates carry shamt in [24:20]; [31:25] is an
                // opcode extension rather than immediate bits.
                if (funct3 == F3_SLL) begin
                    b       = shamt;
                    illegal = (funct7 != F7_BASE);
                end else if (funct3 == F3_SR) begin
                    b = shamt;
                    if (funct7 == F7_ALT) begin
                        ctrl = ALU_SRA;
                    end else if (funct7 != F7_BASE) begin
                        illegal = 1'b1;
                    end
                end
            end

`ifdef ALU_ISSUE_UPPER_EN
            OPC_LUI: begin
                a = '0;
                b = imm_u;
            end

            OPC_AUIPC: begin
                a = pc;
                b = imm_u;
            end
`endif

            default: begin
                illegal = 1'b1;
            end
        endcase

        if (illegal) begin
            a    = '0;
            b    = '0;
            ctrl = ALU_ADD;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue
// ID/EX issue stage feeding the alu block. Decodes RV32I OP / OP-IMM into
// Alu_ctrl plus operands (via alu_dec) and holds the result in a single
// pipeline slot with valid/ready handshakes on both sides and a flush.
//
// Optional feature macro: ALU_ISSUE_UPPER_EN (LUI / AUIPC decode, see alu_dec)
//
// Ports:
//   clk        in   1     clock, rising edge
//   rst_n      in   1     synchronous active-low reset
//   flush      in   1     kill held slot and current input
//   in_valid   in   1     decode side presents an instruction
//   in_ready   out  1     slot can accept this cycle
//   instr      in   32    instruction word
//   rs1_data   in   XLEN  register-file read port 1
//   rs2_data   in   XLEN  register-file read port 2
//   pc         in   XLEN  instruction address (AUIPC only)
//   out_valid  out  1     slot holds an issued op
//   out_ready  in   1     EX consumes the slot
//   alu_a      out  XLEN  alu.a
//   alu_b      out  XLEN  alu.b
//   alu_ctrl   out  4     alu.Alu_ctrl
//   rd         out  5     destination register
//   wb_en      out  1     write-back enable
//   illegal    out  1     issued op failed decode
// -----------------------------------------------------------------------------
module alu_issue #(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [3:0]       alu_ctrl,
    output logic [4:0]       rd,
    output logic             wb_en,
    output logic             illegal
);
    import alu_pkg::*;

    // Decode (stage p0, combinational)
    logic [XLEN-1:0] a_p0;
    logic [XLEN-1:0] b_p0;
    logic [3:0]      ctrl_p0;
    logic            illegal_p0;
    logic [4:0]      rd_p0;
    logic            wb_en_p0;
    logic            load;

    alu_dec #(
        .XLEN (XLEN)
    ) u_dec (
        .instr    (instr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .pc       (pc),
        .a        (a_p0),
        .b        (b_p0),
        .ctrl     (ctrl_p0),
        .illegal  (illegal_p0)
    );

    assign rd_p0    = instr[11:7];
    assign wb_en_p0 = !illegal_p0 && (rd_p0 != 5'd0);

    // Issue slot (stage p1, registered)
    logic            vld_p1;
    logic [XLEN-1:0] a_p1;
    logic [XLEN-1:0] b_p1;
    logic [3:0]      ctrl_p1;
    logic [4:0]      rd_p1;
    logic            wb_en_p1;
    logic            illegal_p1;

    assign in_ready = !vld_p1 || out_ready;
    assign load     = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            a_p1       <= '0;
            b_p1       <= '0;
            ctrl_p1    <= ALU_ADD;
            rd_p1      <= '0;
            wb_en_p1   <= 1'b0;
            illegal_p1 <= 1'b0;
        end else begin
            // Flush wins over load and consume; data registers may go stale.
            if (flush) begin
                vld_p1 <= 1'b0;
            end else if (load) begin
                vld_p1 <= 1'b1;
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end

            // Data only moves on a load, so a held op stays stable.
            if (load) begin
                a_p1       <= a_p0;
                b_p1       <= b_p0;
                ctrl_p1    <= ctrl_p0;
                rd_p1      <= rd_p0;
                wb_en_p1   <= wb_en_p0;
                illegal_p1 <= illegal_p0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign alu_a     = a_p1;
    assign alu_b     = b_p1;
    assign alu_ctrl  = ctrl_p1;
    assign rd        = rd_p1;
    assign wb_en     = wb_en_p1;
    assign illegal   = illegal_p1;

endmodule

// File: tb/tb_alu_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_issue
// Self-checking bench for alu_issue. A monitor pushes an expected record for
// every accepted input and pops/compares one for every consumed output.
// Scenario tasks add directed inline checks.
// -----------------------------------------------------------------------------
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        wb;
        logic        ill;
    } exp_t;

    exp_t q[$];

    alu_issue #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .pc        (pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .rd        (rd),
        .wb_en     (wb_en),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode written as a lookup on the instruction fields.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] r1,
                                   input logic [31:0] r2, input logic [31:0] p);
        exp_t        e;
        logic [3:0]  tbl [0:7];
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        tbl = '{4'd0, 4'd5, 4'd9, 4'd8, 4'd4, 4'd6, 4'd3, 4'd2};
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        e      = '0;
        e.rd   = ins[11:7];
        e.ill  = 1'b1;
        if (opc == 7'h33) begin
            e.a = r1;
            e.b = r2;
            if (f7 == 7'h00) begin
                e.ctrl = tbl[f3];
                e.ill  = 1'b0;
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
                e.ctrl = 4'd1;
                e.ill  = 1'b0;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
                e.ctrl = 4'd7;
                e.ill  = 1'b0;
            end
        end else if (opc == 7'h13) begin
            e.a    = r1;
            e.b    = {{20{ins[31]}}, ins[31:20]};
            e.ctrl = tbl[f3];
            e.ill  = 1'b0;
            if (f3 == 3'd1) begin
                e.b   = {27'b0, ins[24:20]};
                e.ill = (f7 != 7'h00);
            end else if (f3 == 3'd5) begin
                e.b = {27'b0, ins[24:20]};
                if (f7 == 7'h20) e.ctrl = 4'd7;
                else if (f7 != 7'h00) e.ill = 1'b1;
            end
        end
`ifdef ALU_ISSUE_UPPER_EN
        else if (opc == 7'h37) begin
            e.a = 32'd0;  e.b = {ins[31:12], 12'h000};  e.ctrl = 4'd0;  e.ill = 1'b0;
        end else if (opc == 7'h17) begin
            e.a = p;      e.b = {ins[31:12], 12'h000};  e.ctrl = 4'd0;  e.ill = 1'b0;
        end
`endif
        if (e.ill) begin
            e.a = 32'd0;  e.b = 32'd0;  e.ctrl = 4'd0;
        end
        e.wb = !e.ill && (e.rd != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c);
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            4'd7: return $unsigned($signed(a) >>> b[4:0]);
            4'd8: return {31'd0, a < b};
            4'd9: return {31'd0, $signed(a) < $signed(b)};
            default: return 32'd0;
        endcase
    endfunction

    // Scoreboard monitor: samples on the falling edge, between driver updates.
    task automatic monitor();
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
            end else begin
                total++;
                if (in_ready !== (!out_valid || out_ready)) begin
                    bad++;
                    $display("FAIL in_ready_fn got=%b want=%b", in_ready, (!out_valid || out_ready));
                end
                if (out_valid && flush) begin
                    if (q.size() > 0) void'(q.pop_front());
                end else if (out_valid && out_ready) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_unexpected got an output with an empty queue");
                    end else begin
                        e   = q.pop_front();
                        got = '{alu_a, alu_b, alu_ctrl, rd, wb_en, illegal};
                        if (got !== e) begin
                            bad++;
                            $display("FAIL sb_output got a=%h b=%h ctrl=%h rd=%0d wb=%b ill=%b want a=%h b=%h ctrl=%h rd=%0d wb=%b ill=%b",
                                     got.a, got.b, got.ctrl, got.rd, got.wb, got.ill,
                                     e.a, e.b, e.ctrl, e.rd, e.wb, e.ill);
                        end
                    end
                end
                if (in_valid && in_ready && !flush)
                    q.push_back(model(instr, rs1_data, rs2_data, pc));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        instr    = ins;
        rs1_data = r1;
        rs2_data = r2;
        in_valid = 1'b1;
    endtask

    task automatic check_zero_outputs(input string tag);
        total++;
        if ({out_valid, alu_a, alu_b, alu_ctrl, rd, wb_en, illegal} !== '0) begin
            bad++;
            $display("FAIL %s got vld=%b a=%h b=%h ctrl=%h rd=%0d wb=%b ill=%b want all zero",
                     tag, out_valid, alu_a, alu_b, alu_ctrl, rd, wb_en, illegal);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;  flush = 1'b0;  out_ready = 1'b0;  pc = 32'h1000;
        drive(32'h002081B3, 32'd1, 32'd2);
        tick(); tick();
        check_zero_outputs("reset_state");
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        rst_n = 1'b1;  in_valid = 1'b0;
        tick();
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        drive(32'h002081B3, 32'd10, 32'd20);
        tick();
        in_valid = 1'b0;
        total++;
        if ({out_valid, alu_a, alu_b, alu_ctrl, rd, wb_en} !== {1'b1, 32'd10, 32'd20, 4'd0, 5'd3, 1'b1}) begin
            bad++;
            $display("FAIL add got vld=%b a=%0d b=%0d ctrl=%h rd=%0d wb=%b want 1 10 20 0 3 1",
                     out_valid, alu_a, alu_b, alu_ctrl, rd, wb_en);
        end
        tick();
    endtask

    task automatic test_sub();
        drive(32'h402081B3, 32'd100, 32'd100);
        tick();
        in_valid = 1'b0;
        total++;
        if (alu_ctrl !== 4'd1) begin
            bad++; $display("FAIL sub_ctrl got=%h want=1", alu_ctrl);
        end
        total++;
        if (alu_ref(alu_a, alu_b, alu_ctrl) !== 32'd0) begin
            bad++; $display("FAIL sub_zero got=%h want=0", alu_ref(alu_a, alu_b, alu_ctrl));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(32'hFF600093, 32'd0, 32'd0);
        tick();
        total++;
        if ({out_valid, alu_b, alu_ctrl} !== {1'b1, 32'hFFFFFFF6, 4'd0}) begin
            bad++; $display("FAIL addi got vld=%b b=%h ctrl=%h want 1 fffffff6 0", out_valid, alu_b, alu_ctrl);
        end
        drive(32'h00209293, 32'hFFFFFFF6, 32'd0);
        tick();
        in_valid = 1'b0;
        total++;
        if ({out_valid, alu_b, alu_ctrl, rd} !== {1'b1, 32'd2, 4'd5, 5'd5}) begin
            bad++; $display("FAIL slli got vld=%b b=%h ctrl=%h rd=%0d want 1 2 5 5", out_valid, alu_b, alu_ctrl, rd);
        end
        tick();
    endtask

    task automatic test_hold();
        logic [73:0] snap;
        out_ready = 1'b0;
        drive(32'h0020A1B3, 32'hFFFFFFF6, 32'd5);
        tick();
        snap = {alu_a, alu_b, alu_ctrl, rd, wb_en};
        // A competing instruction must not be taken while the slot is held.
        drive(32'h002081B3, 32'd7, 32'd8);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (in_ready !== 1'b0) begin
                bad++; $display("FAIL hold_in_ready cycle=%0d got=%b want=0", i, in_ready);
            end
            total++;
            if ({out_valid, alu_a, alu_b, alu_ctrl, rd, wb_en} !== {1'b1, snap} || alu_ctrl !== 4'd9) begin
                bad++;
                $display("FAIL hold_stable cycle=%0d got vld=%b a=%h b=%h ctrl=%h want a=%h b=%h ctrl=9",
                         i, out_valid, alu_a, alu_b, alu_ctrl, snap[73:42], snap[41:10]);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (alu_ref(alu_a, alu_b, alu_ctrl) !== 32'd1) begin
            bad++; $display("FAIL slt_result got=%h want=1", alu_ref(alu_a, alu_b, alu_ctrl));
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL hold_consume got vld=%b want=0", out_valid);
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive(32'h4020F1B3, 32'd5, 32'd6);
        tick();
        total++;
        if ({out_valid, illegal, wb_en, alu_ctrl, alu_a, alu_b} !== {1'b1, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0}) begin
            bad++;
            $display("FAIL illegal_and got vld=%b ill=%b wb=%b ctrl=%h a=%h b=%h want 1 1 0 0 0 0",
                     out_valid, illegal, wb_en, alu_ctrl, alu_a, alu_b);
        end
        drive(32'h123450B7, 32'd9, 32'd9);
        tick();
        in_valid = 1'b0;
        total++;
`ifdef ALU_ISSUE_UPPER_EN
        if ({illegal, alu_a, alu_b, wb_en} !== {1'b0, 32'd0, 32'h12345000, 1'b1}) begin
            bad++; $display("FAIL lui got ill=%b a=%h b=%h wb=%b want 0 0 12345000 1", illegal, alu_a, alu_b, wb_en);
        end
`else
        if ({illegal, alu_a, alu_b, wb_en} !== {1'b1, 32'd0, 32'd0, 1'b0}) begin
            bad++; $display("FAIL lui got ill=%b a=%h b=%h wb=%b want 1 0 0 0", illegal, alu_a, alu_b, wb_en);
        end
`endif
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(32'h002081B3, 32'd1, 32'd2);
        tick();
        out_ready = 1'b1;
        flush     = 1'b1;
        drive(32'h402081B3, 32'd3, 32'd4);
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_held got vld=%b want=0", out_valid);
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_no_capture got vld=%b want=0", out_valid);
        end
    endtask

    task automatic test_reset_mid_hold();
        out_ready = 1'b0;
        drive(32'h0020A1B3, 32'd3, 32'd4);
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        check_zero_outputs("reset_mid_hold");
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [6:0]  opc;
        logic [6:0]  f7;
        logic [31:0] r;
        int          cycles;
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            case ($urandom_range(0, 4))
                0: opc = 7'h33;
                1: opc = 7'h13;
                2: opc = 7'h37;
                3: opc = 7'h17;
                default: opc = r[6:0];
            endcase
            case ($urandom_range(0, 2))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                default: f7 = r[31:25];
            endcase
            pc = $urandom;
            drive({f7, r[24:7], opc}, $urandom, $urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycles    = 0;
        while (q.size() != 0 && cycles < 20) begin
            tick();
            cycles++;
        end
        tick();
        total++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL drain_timeout queue=%0d vld=%b want 0 0", q.size(), out_valid);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = 32'd0;
        rs1_data  = 32'd0;
        rs2_data  = 32'd0;
        pc        = 32'd0;
        fork
            monitor();
        join_none
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_hold();
        test_illegal();
        test_flush();
        test_reset_mid_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
